user_sw_event_ctrl: RTL and testbench

- Converts the debounced push/slide switch levels from the user switch block into discrete events: push short, push long, slide rise, slide fall.
- Sequences per-switch press timing and arbitrates 12 event sources into one FIFO.
- Presents events to a single consumer (register block / LED control) with a valid/ready handshake.
- Sits directly downstream of the switch synchroniser, in the same clock domain, and shares its 1 ms enable tick.

---
 rtl/user_sw_pkg.sv | 45 ++++
 rtl/user_sw_press_fsm.sv | 74 +++++++
 rtl/user_sw_event_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_user_sw_event_ctrl.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/user_sw_pkg.sv
// Shared types for the user switch event controller.
//   evt_type_e   : 2-bit event code presented on oEvtType
//   evt_t        : FIFO entry {event type, switch index}
//   push_state_e : per-push press sequencer states
//   src_to_evt   : maps an arbiter source number (0..11) to its event
package user_sw_pkg;

    localparam int unsigned NUM_SW  = 4;
    localparam int unsigned NUM_SRC = 12;

    typedef enum logic [1:0] {
        EVT_SHORT      = 2'b00,
        EVT_LONG       = 2'b01,
        EVT_SLIDE_RISE = 2'b10,
        EVT_SLIDE_FALL = 2'b11
    } evt_type_e;

    typedef struct packed {
        evt_type_e  evt_type;
        logic [1:0] idx;
    } evt_t;

    typedef enum logic [1:0] {
        PUSH_IDLE  = 2'b00,
        PUSH_PRESS = 2'b01,
        PUSH_HELD  = 2'b10
    } push_state_e;

    // Sources are ordered short0..3, long0..3, slide0..3; the slide type
    // comes from the level captured when the slide edge was seen.
    function automatic evt_t src_to_evt(input int unsigned src,
                                        input logic [NUM_SW-1:0] slide_lvl);
        evt_t       e;
        logic [1:0] idx;
        idx   = 2'(src % NUM_SW);
        e.idx = idx;
        case (src / NUM_SW)
            0:       e.evt_type = EVT_SHORT;
            1:       e.evt_type = EVT_LONG;
            default: e.evt_type = slide_lvl[idx] ? EVT_SLIDE_RISE : EVT_SLIDE_FALL;
        endcase
        return e;
    endfunction

endpackage

// File: rtl/user_sw_press_fsm.sv
// Press sequencer for one push switch.
// Ports:
//   iClk, iRstN : clock, synchronous active-low reset
//   iCke        : 1 ms tick
//   iRise/iFall : edge strobes of the debounced push level
//   oShort      : one-cycle pulse, released before the long threshold
//   oLong       : one-cycle pulse, held for pLongMs ticks (once per press)
module user_sw_press_fsm #(
    parameter int unsigned pLongMs = 1000,
    parameter int unsigned pCntW   = $clog2(pLongMs + 1)
) (
    input  logic iClk,
    input  logic iRstN,
    input  logic iCke,
    input  logic iRise,
    input  logic iFall,
    output logic oShort,
    output logic oLong
);
    import user_sw_pkg::*;

    localparam logic [pCntW-1:0] CNT_LAST = pCntW'(pLongMs - 1);
    localparam logic [pCntW-1:0] CNT_LONG = pCntW'(pLongMs);

    push_state_e      state_q, state_d;
    logic [pCntW-1:0] cnt_q, cnt_d;

    always_ff @(posedge iClk) begin
        if (!iRstN) begin
            state_q <= PUSH_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        oShort  = 1'b0;
        oLong   = 1'b0;
        case (state_q)
            PUSH_IDLE: begin
                if (iRise) begin
                    state_d = PUSH_PRESS;
                    cnt_d   = '0;
                end
            end
            PUSH_PRESS: begin
                // Release is tested first so it wins over a coinciding threshold tick.
                if (iFall) begin
                    oShort  = 1'b1;
                    state_d = PUSH_IDLE;
                end else if (iCke) begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_d   = CNT_LONG;
                        oLong   = 1'b1;
                        state_d = PUSH_HELD;
                    end else begin
                        cnt_d = cnt_q + pCntW'(1);
                    end
                end
            end
            PUSH_HELD: begin
                if (iFall) begin
                    state_d = PUSH_IDLE;
                end
            end
            default: state_d = PUSH_IDLE;
        endcase
    end

endmodule

// File: rtl/user_sw_event_ctrl.sv
// User switch event controller: turns debounced push/slide levels into
// short/long/rise/fall events, arbitrates 12 pending sources into an event
// FIFO and presents the FIFO head with a valid/ready handshake.
// Ports:
//   iSysClk, iSysRst       : clock, synchronous active-low reset
//   iCke                   : 1 ms tick
//   iUserPushSw[3:0]       : debounced push levels (1 = pressed)
//   iUserSlideSw[3:0]      : debounced slide levels
//   oEvtValid/iEvtReady    : head handshake, pop on valid & ready
//   oEvtType, oEvtIdx      : head event (zero while empty)
//   oFifoCnt               : FIFO occupancy
//   oOvf, iOvfClr          : sticky coalesce flag and its clear
module user_sw_event_ctrl #(
    parameter int unsigned pLongMs    = 1000,
    parameter int unsigned pFifoDepth = 4,
    parameter int unsigned pCntW      = $clog2(pLongMs + 1)
) (
    input  logic                          iSysClk,
    input  logic                          iSysRst,
    input  logic                          iCke,
    input  logic [3:0]                    iUserPushSw,
    input  logic [3:0]                    iUserSlideSw,
    output logic                          oEvtValid,
    input  logic                          iEvtReady,
    output logic [1:0]                    oEvtType,
    output logic [1:0]                    oEvtIdx,
    output logic [$clog2(pFifoDepth):0]   oFifoCnt,
    output logic                          oOvf,
    input  logic                          iOvfClr
);
    import user_sw_pkg::*;

    localparam int unsigned PTR_W = $clog2(pFifoDepth);
    localparam int unsigned CNT_W = PTR_W + 1;

    // Priming and edge detection
    logic              primed_q, primed_d;
    logic [NUM_SW-1:0] push_prev_q, push_prev_d;
    logic [NUM_SW-1:0] slide_prev_q, slide_prev_d;
    logic [NUM_SW-1:0] push_rise, push_fall, slide_edge;

    // Press sequencer pulses
    logic [NUM_SW-1:0] short_fire, long_fire;

    // Pending flags and captured slide levels
    logic [NUM_SW-1:0] short_pend_q, short_pend_d;
    logic [NUM_SW-1:0] long_pend_q, long_pend_d;
    logic [NUM_SW-1:0] slide_pend_q, slide_pend_d;
    logic [NUM_SW-1:0] slide_lvl_q, slide_lvl_d;
    logic              ovf_q, ovf_d;
    logic              coalesce;

    // Arbiter
    logic [NUM_SRC-1:0] req, grant_vec;
    logic               grant_any;
    evt_t               wr_evt;

    // FIFO
    evt_t             mem_q [pFifoDepth];
    evt_t             mem_d [pFifoDepth];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             push, pop;
    evt_t             head;

    // Edges are masked until the previous-level registers hold real inputs,
    // so switches already active at reset generate nothing.
    always_comb begin
        primed_d     = 1'b1;
        push_prev_d  = iUserPushSw;
        slide_prev_d = iUserSlideSw;
        push_rise    = '0;
        push_fall    = '0;
        slide_edge   = '0;
        if (primed_q) begin
            push_rise  = iUserPushSw & ~push_prev_q;
            push_fall  = ~iUserPushSw & push_prev_q;
            slide_edge = iUserSlideSw ^ slide_prev_q;
        end
    end

    for (genvar gi = 0; gi < NUM_SW; gi++) begin : g_press
        user_sw_press_fsm #(
            .pLongMs (pLongMs),
            .pCntW   (pCntW)
        ) u_press (
            .iClk   (iSysClk),
            .iRstN  (iSysRst),
            .iCke   (iCke),
            .iRise  (push_rise[gi]),
            .iFall  (push_fall[gi]),
            .oShort (short_fire[gi]),
            .oLong  (long_fire[gi])
        );
    end

    // Fixed-priority grant; bit 0 (short0) is highest.
    always_comb begin
        req       = {slide_pend_q, long_pend_q, short_pend_q};
        grant_vec = '0;
        grant_any = 1'b0;
        wr_evt    = '0;
        if (cnt_q < CNT_W'(pFifoDepth)) begin
            for (int unsigned s = 0; s < NUM_SRC; s++) begin
                if (!grant_any && req[s]) begin
                    grant_any    = 1'b1;
                    grant_vec[s] = 1'b1;
                    wr_evt       = src_to_evt(s, slide_lvl_q);
                end
            end
        end
    end

    // A flag granted this cycle has already been written to the FIFO, so a
    // new fire on it is a fresh event rather than a coalesce.
    always_comb begin
        short_pend_d = (short_pend_q & ~grant_vec[3:0])  | short_fire;
        long_pend_d  = (long_pend_q  & ~grant_vec[7:4])  | long_fire;
        slide_pend_d = (slide_pend_q & ~grant_vec[11:8]) | slide_edge;
        slide_lvl_d  = (slide_lvl_q & ~slide_edge) | (iUserSlideSw & slide_edge);
        coalesce     = |(short_fire & short_pend_q & ~grant_vec[3:0])
                     | |(long_fire  & long_pend_q  & ~grant_vec[7:4])
                     | |(slide_edge & slide_pend_q & ~grant_vec[11:8]);
        ovf_d = ovf_q;
        if (coalesce) begin
            ovf_d = 1'b1;
        end else if (iOvfClr) begin
            ovf_d = 1'b0;
        end
    end

    always_comb begin
        push     = grant_any;
        pop      = oEvtValid & iEvtReady;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (push) begin
            mem_d[wr_ptr_q] = wr_evt;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge iSysClk) begin
        if (!iSysRst) begin
            primed_q     <= 1'b0;
            push_prev_q  <= '0;
            slide_prev_q <= '0;
            short_pend_q <= '0;
            long_pend_q  <= '0;
            slide_pend_q <= '0;
            slide_lvl_q  <= '0;
            ovf_q        <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            cnt_q        <= '0;
            for (int unsigned i = 0; i < pFifoDepth; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            primed_q     <= primed_d;
            push_prev_q  <= push_prev_d;
            slide_prev_q <= slide_prev_d;
            short_pend_q <= short_pend_d;
            long_pend_q  <= long_pend_d;
            slide_pend_q <= slide_pend_d;
            slide_lvl_q  <= slide_lvl_d;
            ovf_q        <= ovf_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            cnt_q        <= cnt_d;
            mem_q        <= mem_d;
        end
    end

    always_comb begin
        head      = mem_q[rd_ptr_q];
        oEvtValid = (cnt_q != '0);
        oEvtType  = oEvtValid ? head.evt_type : 2'b00;
        oEvtIdx   = oEvtValid ? head.idx : 2'b00;
        oFifoCnt  = cnt_q;
        oOvf      = ovf_q;
    end

endmodule

// File: tb/tb_user_sw_event_ctrl.sv
// Scoreboard bench for user_sw_event_ctrl with pLongMs=10, pFifoDepth=4.
module tb_user_sw_event_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cke;
    logic [3:0] push_sw;
    logic [3:0] slide_sw;
    logic       evt_valid;
    logic       evt_ready;
    logic [1:0] evt_type;
    logic [1:0] evt_idx;
    logic [2:0] fifo_cnt;
    logic       ovf;
    logic       ovf_clr;

    int unsigned tests_run    = 0;
    int unsigned tests_failed = 0;
    int unsigned n_deliv      = 0;
    logic [3:0]  sb [$];

    user_sw_event_ctrl #(
        .pLongMs    (10),
        .pFifoDepth (4)
    ) dut (
        .iSysClk      (clk),
        .iSysRst      (rst_n),
        .iCke         (cke),
        .iUserPushSw  (push_sw),
        .iUserSlideSw (slide_sw),
        .oEvtValid    (evt_valid),
        .iEvtReady    (evt_ready),
        .oEvtType     (evt_type),
        .oEvtIdx      (evt_idx),
        .oFifoCnt     (fifo_cnt),
        .oOvf         (ovf),
        .iOvfClr      (ovf_clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance n clock edges, then settle 1 time unit past the edge.
    task automatic cyc(input int unsigned n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic tick();
        cke = 1'b1;
        cyc(1);
        cke = 1'b0;
        cyc(2);
    endtask

    // Each accepted head is compared against the oldest expected event.
    always @(negedge clk) begin
        if (evt_valid && evt_ready) begin
            if (sb.size() == 0) begin
                chk("unexp_evt", {28'd0, evt_type, evt_idx}, 32'hFFFF_FFFF);
            end else begin
                chk("evt", {28'd0, evt_type, evt_idx}, {28'd0, sb.pop_front()});
                n_deliv++;
            end
        end
    end

    initial begin
        rst_n     = 1'b0;
        cke       = 1'b0;
        push_sw   = '0;
        slide_sw  = '0;
        evt_ready = 1'b1;
        ovf_clr   = 1'b0;
        cyc(3);
        chk("rst_valid", evt_valid, 0);
        chk("rst_type", evt_type, 0);
        chk("rst_idx", evt_idx, 0);
        chk("rst_cnt", fifo_cnt, 0);
        chk("rst_ovf", ovf, 0);
        rst_n = 1'b1;
        cyc(3);

        // Short press on push1 with 2-cycle latency
        push_sw[1] = 1'b1;
        cyc(2);
        repeat (5) tick();
        push_sw[1] = 1'b0;
        sb.push_back(4'b0001);
        cyc(1);
        chk("lat1_valid", evt_valid, 0);
        cyc(1);
        chk("lat2_valid", evt_valid, 1);
        chk("lat2_head", {evt_type, evt_idx}, 4'b0001);
        cyc(3);
        chk("short1_deliv", n_deliv, 1);

        // Long press on push2: event on the 10th tick, none on release
        push_sw[2] = 1'b1;
        cyc(2);
        repeat (9) tick();
        cyc(3);
        chk("long_not_yet", n_deliv, 1);
        sb.push_back(4'b0110);
        tick();
        cyc(4);
        chk("long_deliv", n_deliv, 2);
        repeat (5) tick();
        push_sw[2] = 1'b0;
        cyc(5);
        chk("long_release", n_deliv, 2);

        // Simultaneous push0 release and slide3 rise
        push_sw[0] = 1'b1;
        cyc(2);
        push_sw[0]  = 1'b0;
        slide_sw[3] = 1'b1;
        sb.push_back(4'b0000);
        sb.push_back(4'b1011);
        cyc(2);
        chk("simul_head1", {evt_valid, evt_type, evt_idx}, 5'b10000);
        cyc(1);
        chk("simul_head2", {evt_valid, evt_type, evt_idx}, 5'b11011);
        chk("simul_pushpop_cnt", fifo_cnt, 1);
        cyc(3);
        chk("simul_deliv", n_deliv, 4);

        // Full FIFO: six events at once, four stored, two wait
        evt_ready = 1'b0;
        push_sw   = 4'b1011;
        cyc(2);
        push_sw     = 4'b0000;
        slide_sw[1] = 1'b1;
        slide_sw[2] = 1'b1;
        slide_sw[3] = 1'b0;
        sb.push_back(4'b0000);
        sb.push_back(4'b0001);
        sb.push_back(4'b0011);
        sb.push_back(4'b1001);
        sb.push_back(4'b1010);
        sb.push_back(4'b1111);
        cyc(8);
        chk("full_cnt", fifo_cnt, 4);
        chk("full_head", {evt_type, evt_idx}, 4'b0000);
        chk("full_ovf", ovf, 0);
        evt_ready = 1'b1;
        cyc(12);
        chk("full_deliv", n_deliv, 10);
        chk("full_drain_cnt", fifo_cnt, 0);
        chk("full_drain_ovf", ovf, 0);

        // Coalescing on slide0 while the FIFO is full
        evt_ready  = 1'b0;
        push_sw[2] = 1'b1;
        cyc(2);
        push_sw[2]  = 1'b0;
        slide_sw[1] = 1'b0;
        slide_sw[2] = 1'b0;
        slide_sw[3] = 1'b1;
        sb.push_back(4'b0010);
        sb.push_back(4'b1101);
        sb.push_back(4'b1110);
        sb.push_back(4'b1011);
        cyc(6);
        chk("coal_full_cnt", fifo_cnt, 4);
        slide_sw[0] = 1'b1;
        cyc(2);
        slide_sw[0] = 1'b0;
        sb.push_back(4'b1100);
        cyc(2);
        chk("coal_ovf", ovf, 1);
        chk("coal_cnt", fifo_cnt, 4);
        ovf_clr = 1'b1;
        cyc(1);
        ovf_clr = 1'b0;
        chk("ovf_clr", ovf, 0);
        slide_sw[0] = 1'b1;
        ovf_clr     = 1'b1;
        cyc(1);
        ovf_clr = 1'b0;
        chk("ovf_set_wins", ovf, 1);
        slide_sw[0] = 1'b0;
        cyc(2);
        evt_ready = 1'b1;
        cyc(12);
        chk("coal_deliv", n_deliv, 15);
        chk("coal_ovf_sticky", ovf, 1);

        // Reset mid-operation with queued events and push1 held
        evt_ready  = 1'b0;
        push_sw[3] = 1'b1;
        push_sw[1] = 1'b1;
        cyc(2);
        push_sw[3]  = 1'b0;
        slide_sw[0] = 1'b1;
        slide_sw[1] = 1'b1;
        sb.push_back(4'b0011);
        sb.push_back(4'b1000);
        sb.push_back(4'b1001);
        cyc(6);
        chk("pre_rst_cnt", fifo_cnt, 3);
        chk("pre_rst_head", {evt_type, evt_idx}, 4'b0011);
        rst_n       = 1'b0;
        slide_sw[0] = 1'b0;
        slide_sw[1] = 1'b0;
        slide_sw[2] = 1'b1;
        cyc(1);
        sb.delete();
        chk("mid_rst_valid", evt_valid, 0);
        chk("mid_rst_type", evt_type, 0);
        chk("mid_rst_idx", evt_idx, 0);
        chk("mid_rst_cnt", fifo_cnt, 0);
        chk("mid_rst_ovf", ovf, 0);
        cyc(2);
        rst_n     = 1'b1;
        evt_ready = 1'b1;
        cyc(6);
        chk("prime_no_evt", n_deliv, 15);
        chk("prime_valid", evt_valid, 0);
        push_sw[1] = 1'b0;
        cyc(6);
        chk("held_release_no_evt", n_deliv, 15);
        slide_sw[2] = 1'b0;
        sb.push_back(4'b1110);
        cyc(5);
        chk("post_rst_live", n_deliv, 16);
        chk("sb_empty", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
